// File: rtl/oled_text_writer_pkg.sv
// Shared constants and types for the OLED text writer.
// ASCII control codes, FSM state encoding, default geometry.
package oled_text_pkg;

    localparam int DEF_COLS = 16;
    localparam int DEF_ROWS = 4;

    localparam logic [7:0] ASCII_BLANK = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_BS    = 8'h08;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        PUT,
        BLANKROW,
        SCROLL_CP,
        SCROLL_FILL
    } state_t;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/oled_text_writer_if.sv
// Byte stream from the CPU bus bridge into the text writer.
// Plain valid/ready; a byte moves when in_valid && in_ready.
interface oled_text_writer_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/oled_text_writer.sv
// 4x16 text terminal writer for the OLED character RAM.
// Define OLED_TEXT_SCROLL_EN to scroll on last-row newline instead of wrapping.
module oled_text_writer
    import oled_text_pkg::*;
#(
    parameter int         COLS  = DEF_COLS,
    parameter int         ROWS  = DEF_ROWS,
    parameter logic [7:0] BLANK = ASCII_BLANK
) (
    input  logic                                 clk,
    input  logic                                 rst,
    oled_text_writer_if.slave                    stream,
    output logic                                 ram_we,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] ram_waddr,
    output logic [7:0]                           ram_wdata,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] ram_raddr,
    input  logic [7:0]                           ram_rdata,
    output logic [$clog2(ROWS)-1:0]              cursor_row,
    output logic [$clog2(COLS)-1:0]              cursor_col,
    output logic                                 update_req
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = RW + CW;
    localparam int NW = AW + 1;

    localparam logic [NW-1:0] CLR_LAST = NW'(ROWS * COLS - 1);
    localparam logic [NW-1:0] ROW_END  = NW'(COLS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

`ifdef OLED_TEXT_SCROLL_EN
    localparam logic [NW-1:0] CP_LAST   = NW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] SRC_BASE  = AW'(COLS);
    localparam logic [AW-1:0] FILL_BASE = AW'((ROWS - 1) * COLS);
`endif

    state_t        state, state_n;
    state_t        nl_state;
    logic [NW-1:0] cnt, cnt_n;
    logic [RW-1:0] row, row_n, nl_row;
    logic [CW-1:0] col, col_n;
    logic [7:0]    chr, chr_n;

    logic          rdy, rdy_n;
    logic          we_n;
    logic [AW-1:0] waddr_n;
    logic [AW-1:0] raddr_n;
    logic [7:0]    wdata_n;
    logic          upd_n;
    logic          accept;

    assign accept          = stream.in_valid && rdy && (state == IDLE);
    assign stream.in_ready = rdy;
    assign cursor_row      = row;
    assign cursor_col      = col;

`ifndef OLED_TEXT_SCROLL_EN
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            chr        <= BLANK;
            rdy        <= 1'b0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= BLANK;
            ram_raddr  <= '0;
            update_req <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            row        <= row_n;
            col        <= col_n;
            chr        <= chr_n;
            rdy        <= rdy_n;
            ram_we     <= we_n;
            ram_waddr  <= waddr_n;
            ram_wdata  <= wdata_n;
            ram_raddr  <= raddr_n;
            update_req <= upd_n;
        end
    end

    always_comb begin
        // where a newline lands from the current row
        nl_row   = row + RW'(1);
        nl_state = BLANKROW;
        if (row == ROW_LAST) begin
`ifdef OLED_TEXT_SCROLL_EN
            nl_row   = row;
            nl_state = SCROLL_CP;
`else
            nl_row   = '0;
`endif
        end

        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        col_n   = col;
        chr_n   = chr;

        case (state)
            CLEAR: begin
                cnt_n = cnt + NW'(1);
                if (cnt == CLR_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            IDLE: begin
                if (accept) begin
                    chr_n = stream.in_data;
                    unique case (1'b1)
                        is_print(stream.in_data): begin
                            state_n = PUT;
                        end
                        stream.in_data == ASCII_CR: begin
                            col_n = '0;
                        end
                        stream.in_data == ASCII_LF: begin
                            col_n   = '0;
                            row_n   = nl_row;
                            state_n = nl_state;
                            cnt_n   = '0;
                        end
                        stream.in_data == ASCII_FF: begin
                            state_n = CLEAR;
                            cnt_n   = '0;
                        end
                        stream.in_data == ASCII_BS: begin
                            if (col != '0)
                                state_n = PUT;
                        end
                        default: ;
                    endcase
                end
            end
            PUT: begin
                if (chr == ASCII_BS) begin
                    col_n   = col - CW'(1);
                    state_n = IDLE;
                end else if (col == COL_LAST) begin
                    col_n   = '0;
                    row_n   = nl_row;
                    state_n = nl_state;
                    cnt_n   = '0;
                end else begin
                    col_n   = col + CW'(1);
                    state_n = IDLE;
                end
            end
            BLANKROW: begin
                cnt_n = cnt + NW'(1);
                if (cnt == ROW_END) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
`ifdef OLED_TEXT_SCROLL_EN
            SCROLL_CP: begin
                cnt_n = cnt + NW'(1);
                if (cnt == CP_LAST) begin
                    state_n = SCROLL_FILL;
                    cnt_n   = '0;
                end
            end
            SCROLL_FILL: begin
                cnt_n = cnt + NW'(1);
                if (cnt == ROW_END) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
`endif
            default: begin
                state_n = CLEAR;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        rdy_n   = (state_n == IDLE) && !accept;
        upd_n   = (state != IDLE) && (state_n == IDLE);
        we_n    = 1'b0;
        waddr_n = ram_waddr;
        wdata_n = ram_wdata;
        raddr_n = '0;

        case (state)
            CLEAR: begin
                we_n    = 1'b1;
                waddr_n = cnt[AW-1:0];
                wdata_n = BLANK;
            end
            PUT: begin
                we_n = 1'b1;
                if (chr == ASCII_BS) begin
                    waddr_n = {row, col - CW'(1)};
                    wdata_n = BLANK;
                end else begin
                    waddr_n = {row, col};
                    wdata_n = chr;
                end
            end
            BLANKROW: begin
                we_n    = 1'b1;
                waddr_n = {row, cnt[CW-1:0]};
                wdata_n = BLANK;
            end
`ifdef OLED_TEXT_SCROLL_EN
            SCROLL_CP: begin
                // read runs one entry ahead; data for k arrives at cnt k+1
                if (cnt != '0) begin
                    we_n    = 1'b1;
                    waddr_n = AW'(cnt - NW'(1));
                    wdata_n = ram_rdata;
                end
                if (cnt < CP_LAST - NW'(1))
                    raddr_n = SRC_BASE + AW'(cnt) + AW'(1);
            end
            SCROLL_FILL: begin
                we_n    = 1'b1;
                waddr_n = FILL_BASE + cnt[AW-1:0];
                wdata_n = BLANK;
            end
`endif
            default: ;
        endcase

`ifdef OLED_TEXT_SCROLL_EN
        if (state_n == SCROLL_CP && state != SCROLL_CP)
            raddr_n = SRC_BASE;
`endif
    end

endmodule

// File: tb/tb_oled_text_writer.sv
// Bench for oled_text_writer: RAM model plus a terminal-level
// screen model driven by directed and random byte streams.
module tb_oled_text_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       scrub;
    logic       ram_we;
    logic [5:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [5:0] ram_raddr;
    logic [7:0] ram_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       update_req;

    logic [7:0] mem [64];
    logic [7:0] scr [64];
    int         upd_cnt = 0;
    int         wr_cnt  = 0;
    int         n_chk   = 0;
    int         n_err   = 0;
    int         mrow, mcol, exp_upd, upd_base, busy;

    oled_text_writer_if stream ();

    oled_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .stream     (stream),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .update_req (update_req)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= 8'hFF;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr];
    end

    always @(posedge clk) begin
        if (update_req)
            upd_cnt <= upd_cnt + 1;
        if (ram_we)
            wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic blank_row(input int r);
        for (int c = 0; c < 16; c++)
            scr[r * 16 + c] = 8'h20;
    endtask

    task automatic model_nl();
        mcol = 0;
        if (mrow < 3) begin
            mrow++;
            blank_row(mrow);
        end else begin
`ifdef OLED_TEXT_SCROLL_EN
            for (int i = 0; i < 48; i++)
                scr[i] = scr[i + 16];
            blank_row(3);
`else
            mrow = 0;
            blank_row(0);
`endif
        end
    endtask

    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow * 16 + mcol] = b;
            exp_upd++;
            if (mcol == 15)
                model_nl();
            else
                mcol++;
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            model_nl();
            exp_upd++;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 64; i++)
                scr[i] = 8'h20;
            mrow = 0;
            mcol = 0;
            exp_upd++;
        end else if (b == 8'h08 && mcol > 0) begin
            mcol--;
            scr[mrow * 16 + mcol] = 8'h20;
            exp_upd++;
        end
    endtask

    task automatic compare_screen(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== scr[i])
                bad++;
        check({tag, ":screen"}, bad, 0);
        check({tag, ":row"}, cursor_row, mrow);
        check({tag, ":col"}, cursor_col, mcol);
        check({tag, ":updates"}, upd_cnt - upd_base, exp_upd);
    endtask

    task automatic wait_idle(output int lo);
        int t;
        lo = 0;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (stream.in_ready)
                break;
            lo++;
        end
        if (t >= 300)
            check("idle_timeout", 0, 1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        while (!stream.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300)
            check("ready_timeout", 0, 1);
        stream.in_valid = 1'b1;
        stream.in_data  = b;
        @(posedge clk);
        #1;
        stream.in_valid = 1'b0;
        stream.in_data  = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        push_byte(b);
        model_apply(b);
        wait_idle(busy);
        @(posedge clk);
        #1;
        compare_screen(tag);
    endtask

    task automatic reset_and_clear(input string tag);
        int n;
        int w0;
        bit first = 0;
        rst   = 1'b1;
        scrub = 1'b1;
        stream.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, ":rst_ready"}, stream.in_ready, 0);
        check({tag, ":rst_we"}, ram_we, 0);
        check({tag, ":rst_wdata"}, ram_wdata, 8'h20);
        check({tag, ":rst_raddr"}, ram_raddr, 0);
        check({tag, ":rst_cursor"}, {cursor_row, cursor_col}, 0);
        check({tag, ":rst_upd"}, update_req, 0);
        scrub = 1'b0;
        for (int i = 0; i < 64; i++)
            scr[i] = 8'h20;
        mrow     = 0;
        mcol     = 0;
        exp_upd  = 1;
        upd_base = upd_cnt;
        w0       = wr_cnt;
        rst      = 1'b0;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ram_we && !first) begin
                first = 1;
                check({tag, ":first_waddr"}, ram_waddr, 0);
            end
            if (update_req)
                break;
        end
        check({tag, ":clr_latency"}, (n == 64 || n == 65), 1);
        check({tag, ":clr_ready"}, stream.in_ready, 1);
        @(posedge clk);
        #1;
        check({tag, ":clr_writes"}, wr_cnt - w0, 64);
        compare_screen(tag);
    endtask

    initial begin
        int w0;
        int u0;
        logic [7:0] b;
        stream.in_valid = 1'b0;
        stream.in_data  = 8'h00;
        rst   = 1'b1;
        scrub = 1'b0;

        reset_and_clear("t1");

        send_byte("H", "t2_h");
        send_byte("I", "t2_i");
        check("t2_addr0", mem[0], 8'h48);
        check("t2_addr1", mem[1], 8'h49);
        check("t2_cursor", {cursor_row, cursor_col}, {2'd0, 4'd2});

        send_byte(8'h0C, "t3_ff");
        for (int i = 0; i < 17; i++)
            send_byte("A", "t3_a");
        check("t3_addr16", mem[16], "A");
        check("t3_addr17", mem[17], 8'h20);
        check("t3_cursor", {cursor_row, cursor_col}, {2'd1, 4'd1});

        send_byte(8'h0C, "t4_ff");
        for (int i = 0; i < 16; i++) send_byte("a", "t4_fill");
        for (int i = 0; i < 16; i++) send_byte("b", "t4_fill");
        for (int i = 0; i < 16; i++) send_byte("c", "t4_fill");
        for (int i = 0; i < 15; i++) send_byte("d", "t4_fill");
        send_byte(8'h0A, "t4_lf");
`ifdef OLED_TEXT_SCROLL_EN
        check("t4_busy", busy, 65);
        check("t4_row0", mem[0], "b");
        check("t4_row2", mem[32], "d");
        check("t4_cursor", {cursor_row, cursor_col}, {2'd3, 4'd0});
`else
        check("t4_busy", busy, 16);
        check("t4_row0", mem[0], 8'h20);
        check("t4_row2", mem[32], "c");
        check("t4_cursor", {cursor_row, cursor_col}, {2'd0, 4'd0});
`endif

        send_byte(8'h0C, "t5_ff");
        w0 = wr_cnt;
        u0 = upd_cnt;
        send_byte(8'h08, "t5_bs0");
        check("t5_bs0_writes", wr_cnt - w0, 0);
        check("t5_bs0_upd", upd_cnt - u0, 0);
        for (int i = 0; i < 5; i++)
            send_byte("x", "t5_x");
        send_byte(8'h08, "t5_bs5");
        check("t5_addr4", mem[4], 8'h20);
        check("t5_cursor", {cursor_row, cursor_col}, {2'd0, 4'd4});

        for (int i = 0; i < 3; i++)
            send_byte(8'h0A, "t6_lf");
        push_byte(8'h0A);
        repeat (10) @(negedge clk);
        reset_and_clear("t6");
        w0 = wr_cnt;
        send_byte(8'h07, "t6_bel");
        check("t6_bel_writes", wr_cnt - w0, 0);
        check("t6_bel_busy", busy, 1);

        for (int i = 0; i < 300; i++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p < 70)      b = 8'($urandom_range(32, 126));
            else if (p < 80) b = 8'h0A;
            else if (p < 85) b = 8'h0D;
            else if (p < 92) b = 8'h08;
            else if (p < 94) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
